// File: rtl/floor_request_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : floor_request_unit_if
//  Purpose  : Bundles the floor-request unit's button, FSM-feedback and
//             request signals so they travel as a single port.
//  Modports : master - button/FSM side (drives btn_raw, slow_clk, c_f;
//                      observes req, pending, q_count, press_evt)
//             slave  - floor_request_unit itself
//  Signals  : btn_raw   [NUM_FLOORS] raw buttons, async to clk
//             slow_clk  [1]          divided FSM clock, used only as data
//             c_f       [2]          current floor reported by the FSM
//             req       [NUM_FLOORS] one-hot head-of-queue request
//             pending   [NUM_FLOORS] bitmap of queued floors
//             q_count   [clog2(NUM_FLOORS+1)] queued request count
//             press_evt [NUM_FLOORS] one-cycle pulse per accepted press
//  Revision : 1.0 - initial release
// ============================================================================
interface floor_request_unit_if #(
    parameter int NUM_FLOORS = 3
);
    localparam int c_CW = $clog2(NUM_FLOORS + 1);

    logic [NUM_FLOORS-1:0] btn_raw;
    logic                  slow_clk;
    logic [1:0]            c_f;
    logic [NUM_FLOORS-1:0] req;
    logic [NUM_FLOORS-1:0] pending;
    logic [c_CW-1:0]       q_count;
    logic [NUM_FLOORS-1:0] press_evt;

    modport master (
        output btn_raw, slow_clk, c_f,
        input  req, pending, q_count, press_evt
    );

    modport slave (
        input  btn_raw, slow_clk, c_f,
        output req, pending, q_count, press_evt
    );
endinterface
`default_nettype wire

// File: rtl/floor_request_unit.sv
`default_nettype none
// ============================================================================
//  Module   : floor_request_unit
//  Purpose  : Input stage of the elevator controller. Synchronises and
//             debounces the floor push-buttons, turns each accepted press
//             into a one-cycle event, keeps an in-order duplicate-free queue
//             of requested floors and presents the oldest one as a one-hot
//             level to the floor FSM until the FSM reports arrival there.
//  Ports    : clk    - fast system clock
//             reset  - asynchronous, active-high
//             bus    - floor_request_unit_if.slave (btn_raw, slow_clk, c_f
//                      in; req, pending, q_count, press_evt out)
//  Options  : REQ_CANCEL_EN - when defined, pressing an already pending
//             floor removes it from the queue instead of being ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module floor_request_unit #(
    parameter int NUM_FLOORS      = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 20
) (
    input  wire logic           clk,
    input  wire logic           reset,
    floor_request_unit_if.slave bus
);

    localparam int              c_FW      = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;
    localparam int              c_CW      = $clog2(NUM_FLOORS + 1);
    localparam logic [CNT_W-1:0] c_DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Button conditioning: 2-flop synchroniser, debounce, press edge
    // ------------------------------------------------------------------
    logic [NUM_FLOORS-1:0] r_btn_s1;
    logic [NUM_FLOORS-1:0] r_btn_s2;
    logic [NUM_FLOORS-1:0] r_stable;
    logic [NUM_FLOORS-1:0] r_press_evt;
    logic [CNT_W-1:0]      r_dcnt [NUM_FLOORS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btn_s1    <= '0;
            r_btn_s2    <= '0;
            r_stable    <= '0;
            r_press_evt <= '0;
            for (int i = 0; i < NUM_FLOORS; i++) begin
                r_dcnt[i] <= '0;
            end
        end else begin
            r_btn_s1 <= bus.btn_raw;
            r_btn_s2 <= r_btn_s1;
            for (int i = 0; i < NUM_FLOORS; i++) begin
                r_press_evt[i] <= 1'b0;
                if (r_btn_s2[i] == r_stable[i]) begin
                    r_dcnt[i] <= '0;
                end else if (r_dcnt[i] == c_DB_LAST) begin
                    // Level accepted; a press is the accepted 0->1 change,
                    // emitted on the same edge the stable level flips.
                    r_stable[i]    <= r_btn_s2[i];
                    r_dcnt[i]      <= '0;
                    r_press_evt[i] <= r_btn_s2[i];
                end else begin
                    r_dcnt[i] <= r_dcnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // slow_clk is only data here: synchronise and detect its rising edge.
    // The 2-cycle delay guarantees the FSM has already acted on req and
    // updated c_f by the time the pop is evaluated.
    // ------------------------------------------------------------------
    logic r_slow_s1;
    logic r_slow_s2;
    logic r_slow_s3;
    logic w_slow_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slow_s1 <= 1'b0;
            r_slow_s2 <= 1'b0;
            r_slow_s3 <= 1'b0;
        end else begin
            r_slow_s1 <= bus.slow_clk;
            r_slow_s2 <= r_slow_s1;
            r_slow_s3 <= r_slow_s2;
        end
    end

    assign w_slow_rise = r_slow_s2 & ~r_slow_s3;

    // ------------------------------------------------------------------
    // Request queue: entries [0 .. r_count-1] are valid, entry 0 is head
    // ------------------------------------------------------------------
    logic [c_FW-1:0]       r_q [NUM_FLOORS];
    logic [NUM_FLOORS-1:0] r_pend;
    logic [NUM_FLOORS-1:0] r_req;
    logic [c_CW-1:0]       r_count;

    logic [c_FW-1:0]       w_q_nxt [NUM_FLOORS];
    logic [NUM_FLOORS-1:0] w_pend_nxt;
    logic [NUM_FLOORS-1:0] w_req_nxt;
    logic [c_CW-1:0]       w_cnt_nxt;
    logic                  w_cf_match;
    logic                  w_pop;
    logic                  w_push;
`ifdef REQ_CANCEL_EN
    logic                  w_found;
`endif

    // c_f values that are not a real floor can never match the head.
    assign w_cf_match = (int'(bus.c_f) < NUM_FLOORS) && (int'(bus.c_f) == int'(r_q[0]));
    assign w_pop      = w_slow_rise && (r_count != '0) && w_cf_match;

    always_comb begin
        w_q_nxt    = r_q;
        w_pend_nxt = r_pend;
        w_cnt_nxt  = r_count;
        w_push     = 1'b0;
`ifdef REQ_CANCEL_EN
        w_found    = 1'b0;
`endif

        // Pop is applied first so a same-cycle push lands behind it.
        if (w_pop) begin
            w_pend_nxt[r_q[0]] = 1'b0;
            for (int k = 0; k < NUM_FLOORS - 1; k++) begin
                w_q_nxt[k] = r_q[k+1];
            end
            w_q_nxt[NUM_FLOORS-1] = '0;
            w_cnt_nxt = r_count - c_CW'(1);
        end

        // Ascending index order fixes the order of simultaneous presses.
        for (int i = 0; i < NUM_FLOORS; i++) begin
            w_push = r_press_evt[i] && !w_pend_nxt[i];
`ifdef REQ_CANCEL_EN
            // A press of the entry being popped is absorbed by the pop.
            if (w_pop && (r_q[0] == c_FW'(i))) begin
                w_push = 1'b0;
            end
            if (r_press_evt[i] && w_pend_nxt[i]) begin
                // Remove floor i and close the gap behind it.
                w_found = 1'b0;
                for (int k = 0; k < NUM_FLOORS - 1; k++) begin
                    if (!w_found && (k < int'(w_cnt_nxt)) && (w_q_nxt[k] == c_FW'(i))) begin
                        w_found = 1'b1;
                    end
                    if (w_found) begin
                        w_q_nxt[k] = w_q_nxt[k+1];
                    end
                end
                if (w_found || ((int'(w_cnt_nxt) == NUM_FLOORS) &&
                                (w_q_nxt[NUM_FLOORS-1] == c_FW'(i)))) begin
                    w_q_nxt[NUM_FLOORS-1] = '0;
                end
                w_pend_nxt[i] = 1'b0;
                w_cnt_nxt     = w_cnt_nxt - c_CW'(1);
            end
`endif
            if (w_push) begin
                for (int k = 0; k < NUM_FLOORS; k++) begin
                    if (k == int'(w_cnt_nxt)) begin
                        w_q_nxt[k] = c_FW'(i);
                    end
                end
                w_pend_nxt[i] = 1'b1;
                w_cnt_nxt     = w_cnt_nxt + c_CW'(1);
            end
        end

        // req is derived from the next queue so it is a clean register.
        for (int k = 0; k < NUM_FLOORS; k++) begin
            w_req_nxt[k] = (w_cnt_nxt != '0) && (w_q_nxt[0] == c_FW'(k));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_FLOORS; k++) begin
                r_q[k] <= '0;
            end
            r_pend  <= '0;
            r_req   <= '0;
            r_count <= '0;
        end else begin
            r_q     <= w_q_nxt;
            r_pend  <= w_pend_nxt;
            r_req   <= w_req_nxt;
            r_count <= w_cnt_nxt;
        end
    end

    assign bus.req       = r_req;
    assign bus.pending   = r_pend;
    assign bus.q_count   = r_count;
    assign bus.press_evt = r_press_evt;

endmodule
`default_nettype wire

// File: tb/tb_floor_request_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_floor_request_unit
//  Purpose  : Directed self-checking bench for floor_request_unit with a
//             press-event scoreboard (expected event pushed at stimulus,
//             popped when the DUT pulses press_evt).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_floor_request_unit;

    localparam int NF = 3;

    logic clk = 1'b0;
    logic reset;

    floor_request_unit_if #(.NUM_FLOORS(NF)) bus_if ();

    floor_request_unit #(
        .NUM_FLOORS      (NF),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [NF-1:0] sb_evt [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_state(input string tag, input logic [NF-1:0] e_req,
                               input logic [NF-1:0] e_pend, input logic [1:0] e_cnt);
        check({tag, "_req"}, bus_if.req, e_req);
        check({tag, "_pending"}, bus_if.pending, e_pend);
        check({tag, "_qcount"}, bus_if.q_count, e_cnt);
    endtask

    // Press then release with enough settle time for both debounces.
    task automatic press(input logic [NF-1:0] m);
        bus_if.btn_raw = bus_if.btn_raw | m;
        sb_evt.push_back(m);
        tick(7);
        bus_if.btn_raw = bus_if.btn_raw & ~m;
        tick(7);
    endtask

    task automatic slow_pulse();
        bus_if.slow_clk = 1'b1;
        tick(4);
        bus_if.slow_clk = 1'b0;
        tick(4);
    endtask

    // Scoreboard consumer: every press_evt pulse must match the oldest
    // expected event.
    always @(negedge clk) begin
        if (!reset && bus_if.press_evt != '0) begin
            if (sb_evt.size() == 0) begin
                check("evt_unexpected", bus_if.press_evt, 32'h0);
            end else begin
                check("evt_scoreboard", bus_if.press_evt, sb_evt.pop_front());
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        bus_if.btn_raw  = '0;
        bus_if.slow_clk = 1'b0;
        bus_if.c_f      = 2'd0;
        tick(2);
        reset = 1'b0;
        tick(1);
        check_state("reset", 3'b000, 3'b000, 2'd0);
        check("reset_evt", bus_if.press_evt, 3'b000);

        // Glitch of 3 cycles must be rejected.
        bus_if.btn_raw = 3'b010;
        tick(3);
        bus_if.btn_raw = 3'b000;
        tick(8);
        check_state("glitch", 3'b000, 3'b000, 2'd0);

        // Latency of an accepted press and single-cycle event.
        bus_if.btn_raw = 3'b100;
        sb_evt.push_back(3'b100);
        tick(5);
        check("lat_early", bus_if.press_evt, 3'b000);
        tick(1);
        check("lat_evt", bus_if.press_evt, 3'b100);
        tick(1);
        check("evt_single", bus_if.press_evt, 3'b000);
        check_state("first_push", 3'b100, 3'b100, 2'd1);
        bus_if.btn_raw = 3'b000;
        tick(7);

        // No pop on a wrong floor or on an out-of-range floor.
        bus_if.c_f = 2'd0;
        slow_pulse();
        check_state("cf_mismatch", 3'b100, 3'b100, 2'd1);
        bus_if.c_f = 2'd3;
        slow_pulse();
        check_state("cf_three", 3'b100, 3'b100, 2'd1);

        // Pop exactly three clk after the slow_clk rise.
        bus_if.c_f      = 2'd2;
        bus_if.slow_clk = 1'b1;
        tick(2);
        check("pop_early", bus_if.q_count, 2'd1);
        tick(1);
        check_state("pop", 3'b000, 3'b000, 2'd0);
        bus_if.slow_clk = 1'b0;
        tick(4);

        // Ordering and duplicate press.
        bus_if.c_f = 2'd0;
        press(3'b010);
        press(3'b100);
        check_state("q12", 3'b010, 3'b110, 2'd2);
        press(3'b010);
`ifdef REQ_CANCEL_EN
        check_state("dup_cancel", 3'b100, 3'b100, 2'd1);
`else
        check_state("dup_ignored", 3'b010, 3'b110, 2'd2);
        bus_if.c_f = 2'd1;
        slow_pulse();
        check_state("serve1", 3'b100, 3'b100, 2'd1);
`endif
        bus_if.c_f = 2'd2;
        slow_pulse();
        check_state("serve2", 3'b000, 3'b000, 2'd0);

        // Simultaneous presses queue in ascending order.
        press(3'b101);
        check_state("simul", 3'b001, 3'b101, 2'd2);
        bus_if.c_f = 2'd0;
        slow_pulse();
        check_state("simul_pop0", 3'b100, 3'b100, 2'd1);
        bus_if.c_f = 2'd2;
        slow_pulse();
        check_state("simul_pop2", 3'b000, 3'b000, 2'd0);

        // Re-press of the head on the same edge as its pop.
        press(3'b100);
        check_state("head2", 3'b100, 3'b100, 2'd1);
        bus_if.btn_raw = 3'b100;
        sb_evt.push_back(3'b100);
        tick(4);
        bus_if.slow_clk = 1'b1;
        tick(3);
`ifdef REQ_CANCEL_EN
        check_state("pop_push", 3'b000, 3'b000, 2'd0);
`else
        check_state("pop_push", 3'b100, 3'b100, 2'd1);
`endif
        bus_if.btn_raw  = 3'b000;
        bus_if.slow_clk = 1'b0;
        tick(8);
        slow_pulse();
        check_state("drain", 3'b000, 3'b000, 2'd0);

        // Asynchronous reset mid-queue.
        bus_if.c_f = 2'd0;
        press(3'b010);
        press(3'b100);
        check_state("pre_reset", 3'b010, 3'b110, 2'd2);
        reset = 1'b1;
        #1;
        check_state("async_reset", 3'b000, 3'b000, 2'd0);
        tick(2);
        reset = 1'b0;
        tick(10);
        check_state("post_reset", 3'b000, 3'b000, 2'd0);

        check("sb_empty", sb_evt.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
